// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the data-memory arbiter.
// State encoding, access bundle, word-index macro, default depth.
`define DM_WIDX(a) a[11:2]

package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int DM_WORDS_DEF = 1024;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_acc_t;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a priority pointer.
// Ports: CLK, Reset, req_i[1:0], en_i, valid_o, sel_o.
module rr_arb2
  import dm_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       valid_o,
  output logic       sel_o
);

  // ptr_q = 1 means requester 1 wins a tie
  logic ptr_q, ptr_d;

  assign valid_o = |req_i;

  always_comb begin
    sel_o = 1'b0;
    unique case (req_i)
      2'b10:   sel_o = 1'b1;
      2'b11:   sel_o = ptr_q;
      default: sel_o = 1'b0;
    endcase
  end

  // pointer only moves when a tie is resolved
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && (&req_i))
      ptr_d = ~ptr_q;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter/sequencer for the data memory.
// Ports: m0_* (CPU), m1_* (bridge), dm_* (memory side), CLK, Reset.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ACCESS_LAT = 1,
  parameter int DM_WORDS   = DM_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  // ACCESS_LAT is 1..15, so the countdown fits in 4 bits
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_LAT - 1);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dm_acc_t     acc_q, acc_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;

  logic        idle;
  logic        gnt_v;
  logic        gnt_sel;
  logic        grant;
  logic        last;
  logic [31:0] sel_addr;

  assign idle     = (state_q == ST_IDLE);
  assign grant    = idle && gnt_v;
  assign last     = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign sel_addr = gnt_sel ? m1_addr : m0_addr;

  rr_arb2 u_arb (
    .CLK     (CLK),
    .Reset   (Reset),
    .req_i   ({m1_req, m0_req}),
    .en_i    (idle),
    .valid_o (gnt_v),
    .sel_o   (gnt_sel)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gnt_v) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dm_we    = last && acc_q.we && !acc_q.err;
    m0_ack   = (state_q == ST_RESP) && !acc_q.owner;
    m1_ack   = (state_q == ST_RESP) && acc_q.owner;
    m0_err   = m0_ack && acc_q.err;
    m1_err   = m1_ack && acc_q.err;
    m0_stall = Reset && m0_req && !m0_ack;
    dm_addr  = acc_q.addr;
    dm_wdata = acc_q.wdata;
    m0_rdata = rd0_q;
    m1_rdata = rd1_q;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (grant) begin
      acc_d.owner = gnt_sel;
      acc_d.we    = gnt_sel ? m1_we : m0_we;
      acc_d.err   = (sel_addr[1:0] != 2'b00) ||
                    ({2'b00, sel_addr[31:2]} >= 32'(DM_WORDS));
      acc_d.addr  = {20'b0, `DM_WIDX(sel_addr), 2'b00};
      acc_d.wdata = gnt_sel ? m1_wdata : m0_wdata;
      cnt_d       = CNT_LOAD;
    end else if ((state_q == ST_BUSY) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    // rejected reads return zero instead of memory contents
    if (last && !acc_q.we) begin
      if (acc_q.owner) rd1_d = acc_q.err ? 32'd0 : dm_rdata;
      else             rd0_d = acc_q.err ? 32'd0 : dm_rdata;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
      cnt_q <= 4'd0;
      rd0_q <= 32'd0;
      rd1_q <= 32'd0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed + randomized checks of dm_arbiter
// against a transaction-level timing model.
module tb_dm_arbiter;

  localparam int LAT   = 3;
  localparam int WORDS = 1024;

  logic CLK   = 1'b0;
  logic Reset = 1'b0;

  logic        rq [2];
  logic        wq [2];
  logic [31:0] aq [2];
  logic [31:0] dq [2];

  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err, m0_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we;

  dm_arbiter #(.ACCESS_LAT(LAT), .DM_WORDS(WORDS)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .m0_req   (rq[0]),
    .m0_we    (wq[0]),
    .m0_addr  (aq[0]),
    .m0_wdata (dq[0]),
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_stall (m0_stall),
    .m1_req   (rq[1]),
    .m1_we    (wq[1]),
    .m1_addr  (aq[1]),
    .m1_wdata (dq[1]),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] seed_word(input int i);
    if (i == 3) return 32'hDEADBEEF;
    return 32'h5A5A_0000 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  logic        mem_ready = 1'b0;
  logic [31:0] mem [WORDS];
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= seed_word(i);
    end else if (dm_we) begin
      mem[dm_addr[11:2]] <= dm_wdata;
    end
  end
  assign dm_rdata = mem[dm_addr[11:2]];

  initial begin
    @(posedge CLK);
    #1 mem_ready = 1'b1;
  end

  int tests, fails, cyc;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: one transaction at a time, timed by its grant cycle
  logic [31:0] ref_mem [WORDS];
  int          busy_until;
  bit          fav;
  bit          have_t;
  int          t_g;
  bit          t_own, t_we, t_err;
  int          t_idx;
  logic [31:0] t_rd, t_wd;
  logic [31:0] exp_rd [2];
  logic [31:0] exp_a, exp_d;
  bit          gnt_now;
  bit          gnt_port;

  bit          ob_ack [2];
  bit          ob_err [2];
  logic [31:0] ob_rd  [2];
  bit          ob_we, ob_stall;
  logic [31:0] ob_a;

  task automatic model_reset();
    busy_until = 0;
    fav        = 1'b0;
    have_t     = 1'b0;
    exp_rd[0]  = 32'd0;
    exp_rd[1]  = 32'd0;
    exp_a      = 32'd0;
    exp_d      = 32'd0;
  endtask

  task automatic model_step();
    bit ack_c, we_c, p;
    logic [31:0] a;
    gnt_now   = 1'b0;
    ob_ack[0] = m0_ack;   ob_ack[1] = m1_ack;
    ob_err[0] = m0_err;   ob_err[1] = m1_err;
    ob_rd[0]  = m0_rdata; ob_rd[1]  = m1_rdata;
    ob_we     = dm_we;
    ob_stall  = m0_stall;
    ob_a      = dm_addr;
    if (!Reset) begin
      model_reset();
      checkb("rst_m0_ack", m0_ack, 1'b0);
      checkb("rst_m1_ack", m1_ack, 1'b0);
      checkb("rst_m0_err", m0_err, 1'b0);
      checkb("rst_m1_err", m1_err, 1'b0);
      checkb("rst_dm_we", dm_we, 1'b0);
      checkb("rst_m0_stall", m0_stall, 1'b0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      check("rst_dm_addr", dm_addr, 32'd0);
      check("rst_dm_wdata", dm_wdata, 32'd0);
      return;
    end
    ack_c = have_t && (cyc == t_g + LAT + 1);
    we_c  = have_t && (cyc == t_g + LAT) && t_we && !t_err;
    if (we_c) ref_mem[t_idx] = t_wd;
    if (ack_c && !t_we) exp_rd[t_own] = t_err ? 32'd0 : t_rd;
    checkb("m0_ack", m0_ack, ack_c && !t_own);
    checkb("m1_ack", m1_ack, ack_c && t_own);
    checkb("m0_err", m0_err, ack_c && !t_own && t_err);
    checkb("m1_err", m1_err, ack_c && t_own && t_err);
    checkb("dm_we", dm_we, we_c);
    checkb("m0_stall", m0_stall, rq[0] && !(ack_c && !t_own));
    check("m0_rdata", m0_rdata, exp_rd[0]);
    check("m1_rdata", m1_rdata, exp_rd[1]);
    check("dm_addr", dm_addr, exp_a);
    check("dm_wdata", dm_wdata, exp_d);
    if (cyc >= busy_until && (rq[0] || rq[1])) begin
      if (rq[0] && rq[1]) begin
        p   = fav;
        fav = ~fav;
      end else begin
        p = rq[1];
      end
      a      = aq[p];
      t_own  = p;
      t_we   = wq[p];
      t_wd   = dq[p];
      t_err  = (a % 4 != 0) || (longint'(a) / 4 >= WORDS);
      t_idx  = int'(a[11:2]);
      t_rd   = ref_mem[t_idx];
      t_g    = cyc;
      have_t = 1'b1;
      busy_until = cyc + LAT + 2;
      exp_a  = 32'(t_idx * 4);
      exp_d  = dq[p];
      gnt_now  = 1'b1;
      gnt_port = p;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    step();
    step();
    Reset = 1'b1;
  endtask

  task automatic run_one(
    input  bit          p,
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  bit          pert,
    output int          ack_k,
    output int          we_k,
    output int          we_n,
    output logic [31:0] we_a,
    output logic [31:0] busy_a,
    output logic [31:0] rd,
    output bit          er,
    output int          st_n
  );
    ack_k = -1; we_k = -1; we_n = 0; st_n = 0;
    we_a = 32'd0; busy_a = 32'd0; rd = 32'd0; er = 1'b0;
    rq[p] = 1'b1; wq[p] = w; aq[p] = a; dq[p] = d;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ob_stall) st_n++;
      if (ob_we) begin
        we_n++;
        we_k = k;
        we_a = ob_a;
      end
      if (k == 1) busy_a = ob_a;
      if (pert && k == 0) aq[p] = a + 32'd4;
      if (ob_ack[p]) begin
        ack_k = k;
        rd    = ob_rd[p];
        er    = ob_err[p];
        break;
      end
    end
    rq[p] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    logic [31:0] a;
    s = int'($urandom_range(9));
    a = 32'($urandom_range(15)) << 2;
    if (s == 6 || s == 7)
      a = a | 32'($urandom_range(3, 1));
    else if (s == 8)
      a = 32'h1000 + (32'($urandom_range(255)) << 2);
    else if (s == 9)
      a = ($urandom_range(1) == 1) ? 32'hFFC : $urandom();
    return a;
  endfunction

  task automatic new_req(input int p);
    rq[p] = 1'b1;
    wq[p] = 1'($urandom_range(1));
    aq[p] = rand_addr();
    dq[p] = $urandom();
  endtask

  int          ack_k, we_k, we_n, st_n, n_acc, n_we;
  logic [31:0] we_a, busy_a, rd;
  bit          er;
  int          order [4];

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; wq[p] = 1'b0; aq[p] = 32'd0; dq[p] = 32'd0;
    end
    for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
    model_reset();

    step();
    rq[0] = 1'b1;
    step();
    checkb("lit_stall_in_reset", ob_stall, 1'b0);
    check("lit_rst_dm_addr", ob_a, 32'd0);
    rq[0] = 1'b0;
    step();
    Reset = 1'b1;
    step();

    run_one(1'b0, 1'b0, 32'h0000000C, 32'd0, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    checki("lit_rd_ack_cycle", ack_k, LAT + 1);
    check("lit_rd_data", rd, 32'hDEADBEEF);
    checkb("lit_rd_err", er, 1'b0);
    checki("lit_rd_no_we", we_n, 0);
    checki("lit_rd_stall_cycles", st_n, LAT + 1);

    run_one(1'b1, 1'b1, 32'h00000010, 32'h12345678, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    checki("lit_wr_we_count", we_n, 1);
    checki("lit_wr_we_cycle", we_k, LAT);
    check("lit_wr_we_addr", we_a, 32'h00000010);
    checki("lit_wr_ack_cycle", ack_k, LAT + 1);
    checkb("lit_wr_err", er, 1'b0);
    check("lit_wr_rdata_kept", rd, 32'd0);

    run_one(1'b0, 1'b0, 32'h00000010, 32'd0, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    check("lit_readback", rd, 32'h12345678);

    run_one(1'b0, 1'b1, 32'h00000006, 32'hFFFFFFFF, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    checkb("lit_misalign_err", er, 1'b1);
    checki("lit_misalign_no_we", we_n, 0);
    checki("lit_misalign_ack", ack_k, LAT + 1);

    run_one(1'b1, 1'b0, 32'h00001000, 32'd0, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    checkb("lit_range_err", er, 1'b1);
    check("lit_range_rdata", rd, 32'd0);

    do_reset();
    rq[0] = 1'b1; wq[0] = 1'b0; aq[0] = 32'h0;
    rq[1] = 1'b1; wq[1] = 1'b0; aq[1] = 32'h4;
    n_acc = 0;
    for (int k = 0; k < 40 && n_acc < 4; k++) begin
      step();
      for (int q = 0; q < 2; q++)
        if (ob_ack[q] && n_acc < 4) begin
          order[n_acc] = q;
          n_acc++;
        end
    end
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    checki("lit_rr_count", n_acc, 4);
    checki("lit_rr_0", order[0], 0);
    checki("lit_rr_1", order[1], 1);
    checki("lit_rr_2", order[2], 0);
    checki("lit_rr_3", order[3], 1);
    step();

    rq[1] = 1'b1; wq[1] = 1'b1; aq[1] = 32'h20; dq[1] = 32'hCAFEF00D;
    step();
    step();
    Reset = 1'b0;
    #1;
    checkb("lit_abort_we", dm_we, 1'b0);
    checkb("lit_abort_ack", m1_ack, 1'b0);
    check("lit_abort_addr", dm_addr, 32'd0);
    check("lit_abort_wdata", dm_wdata, 32'd0);
    check("lit_abort_rd0", m0_rdata, 32'd0);
    check("lit_abort_rd1", m1_rdata, 32'd0);
    rq[1] = 1'b0;
    step();
    Reset = 1'b1;
    n_acc = 0;
    n_we  = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ob_ack[0] || ob_ack[1]) n_acc++;
      if (ob_we) n_we++;
    end
    checki("lit_abort_no_ack", n_acc, 0);
    checki("lit_abort_no_we", n_we, 0);
    run_one(1'b0, 1'b0, 32'h00000020, 32'd0, 1'b0,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    checki("lit_after_abort_ack", ack_k, LAT + 1);
    check("lit_after_abort_rd", rd, seed_word(8));

    run_one(1'b0, 1'b0, 32'h00000004, 32'd0, 1'b1,
            ack_k, we_k, we_n, we_a, busy_a, rd, er, st_n);
    check("lit_latched_addr", busy_a, 32'h00000004);
    check("lit_latched_rd", rd, seed_word(1));

    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(499) == 0) begin
        Reset = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        step();
        Reset = 1'b1;
        continue;
      end
      for (int p = 0; p < 2; p++) begin
        if (ob_ack[p]) begin
          if ($urandom_range(1) == 1) new_req(p);
          else rq[p] = 1'b0;
        end else if (gnt_now && int'(gnt_port) == p &&
                     $urandom_range(2) == 0) begin
          aq[p] = $urandom();
          wq[p] = ~wq[p];
          dq[p] = $urandom();
        end else if (!rq[p] && $urandom_range(3) == 0) begin
          new_req(p);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-port data memory.
- Requester 0 is the CPU MEM stage; requester 1 is the loader/debug bridge.
- Grants one requester at a time with round-robin priority and holds the granted request for ACCESS_LAT cycles.
- Issues exactly one memory write strobe per granted write, then returns a registered read word and a one-cycle acknowledge with an error flag.

Parameters:
- ACCESS_LAT, 1, cycles the memory needs per access; legal range is 1 to 15.
- DM_WORDS, 1024, memory depth in 32-bit words; used for the address range check.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU access request; held until m0_ack.
- m0_we  in  1  CPU write enable; 1 = write, 0 = read.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_rdata  out  32  CPU read data; valid while m0_ack=1.
- m0_ack  out  1  CPU access complete; one-cycle pulse.
- m0_err  out  1  CPU access rejected; valid while m0_ack=1.
- m0_stall  out  1  m0_req & ~m0_ack; drives the pipeline freeze.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same directions, widths and meaning, for the bridge port.
- dm_addr  out  32  word-aligned memory address {20'b0, addr[11:2], 2'b0}.
- dm_wdata  out  32  memory write data.
- dm_we  out  1  memory write strobe; one cycle per granted write.
- dm_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, owner=0, priority pointer favours m0, counter=0, both ack and err outputs 0, both rdata outputs 0, dm_we=0, dm_addr=0, dm_wdata=0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester the pointer favours. The pointer then favours the other requester.
  - On grant: latch the owner, we, addr and wdata; load counter=ACCESS_LAT-1; go to BUSY.
  - Error check at grant: err is set if addr[1:0]!=0, or if addr>>2 >= DM_WORDS.
- BUSY:
  - dm_addr and dm_wdata come from the latched request. dm_addr is the registered value, held stable for every BUSY cycle.
  - While counter!=0, decrement the counter. dm_we stays 0.
  - When counter==0:
    - dm_we = latched we & ~err, for this cycle only.
    - dm_rdata is captured into the owner's rdata register; on error it is captured as 0.
    - Go to RESP.
- RESP:
  - The owner's ack is 1 for this cycle. The owner's err equals the latched err.
  - The non-owner's ack and err stay 0.
  - Go to IDLE unconditionally.
- Latency: request first seen in IDLE in cycle t gives ack in cycle t+ACCESS_LAT+1.
- Throughput: one access per ACCESS_LAT+2 cycles.
- Request rules:
  - A requester keeps req, we, addr and wdata stable until its ack.
  - Inputs are latched at grant, so changes after grant have no effect.
  - req still high in IDLE after an ack counts as a new request.
- rdata hold: rdata registers hold their value after ack until that port's next completed read.
- Writes: write completions leave rdata unchanged.
- A write reads back the old word only through a later read. No bypass.
- Reset asserted in BUSY or RESP aborts the access. No ack is issued. A dm_we pulse is cut immediately.
- m0_stall is combinational and is 0 during reset.

Decomposition:
- Shared package dm_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
  - the address-to-word-index macro for bits [11:2];
  - the DM_WORDS default.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a pointer register, CLK and Reset.

Test Plan:
- Single read: ACCESS_LAT=1, memory word 3 = 0xDEADBEEF, m0 read of 0x0000000C at cycle 0 -> m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 2; dm_we never 1; m0_stall=1 in cycles 0-1.
- Single write: m1 write of 0x12345678 to 0x00000010, ACCESS_LAT=3 -> exactly one dm_we pulse in cycle 3 with dm_addr=0x10; m1_ack in cycle 4; m1_err=0.
- Contention: m0 and m1 both request at cycle 0 out of reset -> m0 is acked first; m1 is granted in the next IDLE; with both held continuously, grants alternate m1, m0, m1.
- Errors:
  - write to 0x00000006 -> m0_ack with m0_err=1, and no dm_we;
  - read of 0x00001000 with DM_WORDS=1024 -> err=1 and rdata=0.
- Reset mid-access: Reset low during BUSY of a write, ACCESS_LAT=4 -> no dm_we and no ack; all outputs return to reset values within the same cycle; the next request is served normally.
- Input change after grant: m0_addr changes from 0x4 to 0x8 one cycle after grant -> the access still targets 0x4.
